// File: rtl/hw3_dp_arb.sv
// ============================================================================
// hw3_dp_arb : two-requester round-robin arbiter that streams each granted
//              word MSB-first into a 1101101 detector and counts its matches.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module hw3_dp_arb #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [1:0]         i_req,
   input  logic [2*WIDTH-1:0] i_word,
   output logic [1:0]         o_ack,
   output logic               o_busy,
   output logic               o_det_rst_n,
   output logic               o_det_data,
   input  logic               i_det_find,
   output logic               o_done,
   output logic               o_id,
   output logic [CNT_W-1:0]   o_count
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t             state_q;
   logic               ptr_q;
   logic [WIDTH-1:0]   shreg_q;
   logic [IDX_W-1:0]   idx_q;
   logic [CNT_W-1:0]   count_q;
   logic               id_q;
   logic [1:0]         ack_q;
   logic               busy_q;
   logic               done_q;
   logic               det_rst_n_q;
   logic               det_data_q;

   logic               win_d;
   logic [WIDTH-1:0]   word_d;

   // Contested requests go to the pointer; a lone request wins outright.
   always_comb begin
      win_d = i_req[1];
      if (i_req[0] && i_req[1]) begin
         win_d = ptr_q;
      end
      word_d = win_d ? i_word[2*WIDTH-1:WIDTH] : i_word[WIDTH-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         shreg_q     <= '0;
         idx_q       <= '0;
         count_q     <= '0;
         id_q        <= 1'b0;
         ack_q       <= 2'b00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         det_rst_n_q <= 1'b0;
         det_data_q  <= 1'b0;
      end else begin
         ack_q  <= 2'b00;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               det_rst_n_q <= 1'b0;
               det_data_q  <= 1'b0;
               if (|i_req) begin
                  ack_q       <= win_d ? 2'b10 : 2'b01;
                  ptr_q       <= ~win_d;
                  id_q        <= win_d;
                  count_q     <= '0;
                  idx_q       <= '0;
                  shreg_q     <= {word_d[WIDTH-2:0], 1'b0};
                  det_data_q  <= word_d[WIDTH-1];
                  det_rst_n_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= SHIFT;
               end
            end
            SHIFT: begin
               // At k=0 the detector has just left reset, so its find is stale.
               if (i_det_find && (idx_q != '0)) begin
                  count_q <= count_q + CNT_W'(1);
               end
               if (idx_q == LAST_IDX) begin
                  det_data_q <= 1'b0;
                  state_q    <= DRAIN;
               end else begin
                  idx_q      <= idx_q + IDX_W'(1);
                  det_data_q <= shreg_q[WIDTH-1];
                  shreg_q    <= {shreg_q[WIDTH-2:0], 1'b0};
               end
            end
            DRAIN: begin
               if (i_det_find) begin
                  count_q <= count_q + CNT_W'(1);
               end
               det_rst_n_q <= 1'b0;
               done_q      <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_ack       = ack_q;
   assign o_busy      = busy_q;
   assign o_det_rst_n = det_rst_n_q;
   assign o_det_data  = det_data_q;
   assign o_done      = done_q;
   assign o_id        = id_q;
   assign o_count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_hw3_dp_arb.sv
// ============================================================================
// tb_hw3_dp_arb : directed bench for hw3_dp_arb with a behavioural detector.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_hw3_dp_arb;
   localparam int W  = 16;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req;
   logic [2*W-1:0] word;
   logic [1:0]    ack;
   logic          busy, drn, dd, find, done, oid;
   logic [CW-1:0] cnt_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   hw3_dp_arb #(.WIDTH(W), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_word(word),
      .o_ack(ack), .o_busy(busy), .o_det_rst_n(drn), .o_det_data(dd),
      .i_det_find(find), .o_done(done), .o_id(oid), .o_count(cnt_o)
   );

   // Moore detector model: find is high in the cycle after the 7th bit of a match.
   logic [6:0] hist;
   logic [2:0] nb;
   always @(posedge clk) begin
      if (!drn) begin
         hist <= '0;
         nb   <= '0;
      end else begin
         hist <= {hist[5:0], dd};
         if (nb < 3'd7) nb <= nb + 3'd1;
      end
   end
   assign find = (nb == 3'd7) && (hist == 7'b1101101);

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1);
   end

   task automatic do_word(input int id, input logic [W-1:0] w,
                          output logic [1:0] ackv, output logic busyv, output logic datav,
                          output int lat, output logic [CW-1:0] cnt, output logic idv);
      @(negedge clk);
      req[id] = 1'b1;
      word[id*W +: W] = w;
      ackv = 2'b00; busyv = 1'b0; datav = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack !== 2'b00) begin
            ackv = ack; busyv = busy; datav = dd;
            break;
         end
      end
      req = 2'b00;
      lat = -1; cnt = 'x; idv = 1'bx;
      if (ackv != 2'b00) begin
         for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
               lat = i; cnt = cnt_o; idv = oid;
               break;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 2'b00; word = '0;
      repeat (2) @(negedge clk);
      total++;
      if ({ack, busy, done, oid, cnt_o, drn, dd} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 0", {ack, busy, done, oid, cnt_o, drn, dd});
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({ack, busy, drn} !== 4'b0) begin
         bad++;
         $display("FAIL reset_idle: got %b want 0000", {ack, busy, drn});
      end
   endtask

   task automatic test_basic();
      logic [1:0] a; logic b, d, id; int lat; logic [CW-1:0] c;
      do_word(0, 16'hDA00, a, b, d, lat, c, id);
      total++; if (a !== 2'b01) begin bad++; $display("FAIL basic_ack: got %b want 01", a); end
      total++; if (b !== 1'b1)  begin bad++; $display("FAIL basic_busy: got %b want 1", b); end
      total++; if (d !== 1'b1)  begin bad++; $display("FAIL basic_msb: got %b want 1", d); end
      total++; if (lat != 17)   begin bad++; $display("FAIL basic_latency: got %0d want 17", lat); end
      total++; if (c !== 5'd1)  begin bad++; $display("FAIL basic_count: got %0d want 1", c); end
      total++; if (id !== 1'b0) begin bad++; $display("FAIL basic_id: got %b want 0", id); end
      @(negedge clk);
      total++;
      if ({cnt_o, oid, drn, busy} !== {5'd1, 1'b0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL basic_hold: got cnt=%0d id=%b rstn=%b busy=%b want 1 0 0 0", cnt_o, oid, drn, busy);
      end
   endtask

   task automatic test_overlap();
      logic [1:0] a; logic b, d, id; int lat; logic [CW-1:0] c;
      do_word(1, 16'hDB6D, a, b, d, lat, c, id);
      total++; if (a !== 2'b10) begin bad++; $display("FAIL overlap_ack: got %b want 10", a); end
      total++; if (c !== 5'd4)  begin bad++; $display("FAIL overlap_count: got %0d want 4", c); end
      total++; if (id !== 1'b1) begin bad++; $display("FAIL overlap_id: got %b want 1", id); end
      total++; if (lat != 17)   begin bad++; $display("FAIL overlap_latency: got %0d want 17", lat); end
      do_word(0, 16'h0000, a, b, d, lat, c, id);
      total++; if (d !== 1'b0)  begin bad++; $display("FAIL empty_msb: got %b want 0", d); end
      total++; if (c !== 5'd0)  begin bad++; $display("FAIL empty_count: got %0d want 0", c); end
   endtask

   task automatic test_edge_bits();
      logic [1:0] a; logic b, d, id; int lat; logic [CW-1:0] c;
      do_word(0, 16'h006D, a, b, d, lat, c, id);
      total++; if (c !== 5'd1)  begin bad++; $display("FAIL lastbit_count: got %0d want 1", c); end
      do_word(1, 16'hED00, a, b, d, lat, c, id);
      total++; if (c !== 5'd1)  begin bad++; $display("FAIL prefix_count: got %0d want 1", c); end
      total++; if (id !== 1'b1) begin bad++; $display("FAIL prefix_id: got %b want 1", id); end
   endtask

   task automatic test_arbitration();
      logic [1:0]    ackseq [4];
      int            dcyc   [4];
      logic          did    [4];
      logic [CW-1:0] dcnt   [4];
      int nack = 0, ndone = 0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      word = {16'hDB6D, 16'hDA00};
      req  = 2'b11;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (ack !== 2'b00 && nack < 4) begin ackseq[nack] = ack; nack++; end
         if (done === 1'b1) begin
            dcyc[ndone] = cyc; did[ndone] = oid; dcnt[ndone] = cnt_o; ndone++;
            if (ndone == 4) break;
         end
      end
      req = 2'b00;
      total++;
      if (ndone != 4) begin
         bad++; $display("FAIL arb_done_count: got %0d want 4", ndone);
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (ackseq[i] !== ((i % 2) ? 2'b10 : 2'b01) || did[i] !== 1'((i % 2)) ||
                dcnt[i] !== ((i % 2) ? 5'd4 : 5'd1)) begin
               bad++;
               $display("FAIL arb_grant%0d: got ack=%b id=%b cnt=%0d want alternating from 0", i, ackseq[i], did[i], dcnt[i]);
            end
         end
         for (int i = 1; i < 4; i++) begin
            total++;
            if (dcyc[i] - dcyc[i-1] != 19) begin
               bad++; $display("FAIL arb_spacing%0d: got %0d want 19", i, dcyc[i] - dcyc[i-1]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_shift();
      bit got = 0;
      bit seen_done = 0;
      @(negedge clk);
      word[W-1:0] = 16'hDA00;
      req = 2'b01;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack !== 2'b00) begin got = 1; break; end
      end
      req = 2'b00;
      total++;
      if (!got) begin bad++; $display("FAIL midrst_first_ack: got none want 01"); end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({ack, busy, done, oid, cnt_o, drn, dd} !== '0) begin
         bad++;
         $display("FAIL midrst_outputs: got %b want 0", {ack, busy, done, oid, cnt_o, drn, dd});
      end
      rst = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done === 1'b1 || ack !== 2'b00) seen_done = 1;
      end
      total++;
      if (seen_done) begin bad++; $display("FAIL midrst_no_done: got activity want none"); end
      word = {16'hDB6D, 16'hDA00};
      req  = 2'b11;
      got  = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack !== 2'b00) begin got = 1; break; end
      end
      total++;
      if (!got || ack !== 2'b01) begin bad++; $display("FAIL midrst_regrant: got %b want 01", ack); end
      req = 2'b00;
      got = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin got = 1; break; end
      end
      total++;
      if (!got || oid !== 1'b0 || cnt_o !== 5'd1) begin
         bad++; $display("FAIL midrst_result: got done=%0d id=%b cnt=%0d want 1 0 1", got, oid, cnt_o);
      end
   endtask

   task automatic test_isolation();
      int  last_ack = -1000;
      logic exp_rstn;
      void'($urandom(32'd1234));
      word = {16'hDB6D, 16'hDA00};
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (ack !== 2'b00) begin
            total++;
            if (n - last_ack < 19) begin
               bad++; $display("FAIL iso_ack_gap: got %0d want >=19", n - last_ack);
            end
            last_ack = n;
         end
         exp_rstn = (n - last_ack <= 16);
         total++;
         if (drn !== exp_rstn || (!exp_rstn && dd !== 1'b0)) begin
            bad++; $display("FAIL iso_det_rstn: cycle %0d got rstn=%b data=%b want rstn=%b", n, drn, dd, exp_rstn);
         end
         req = 2'($urandom_range(0, 3));
      end
      req = 2'b00;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overlap();
      test_edge_bits();
      test_arbitration();
      test_reset_mid_shift();
      test_isolation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
